fv_req_arbiter: RTL and testbench

FV_REQ_ARBITER -- requirements
Module: fv_req_arbiter

---
 rtl/fv_req_arbiter_pkg.sv | 28 ++
 rtl/fv_req_arbiter_if.sv | 16 +
 rtl/fv_req_arbiter_rr.sv | 33 +++
 rtl/fv_req_arbiter.sv | 87 ++++++++
 tb/tb_fv_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fv_req_arbiter_pkg.sv
// rtl/fv_req_arbiter_pkg.sv - shared FV system definitions used by the request arbiter slice
`ifndef Num_Edge_PE
`define Num_Edge_PE 4
`endif
`ifndef Max_FV_num
`define Max_FV_num 64
`endif

package fv_req_arbiter_pkg;

  localparam int NUM_EDGE_PE = `Num_Edge_PE;
  localparam int MAX_FV_NUM  = `Max_FV_num;
  localparam int FV_ADDR_W   = $clog2(MAX_FV_NUM) + 1;
  localparam int PE_TAG_W    = (NUM_EDGE_PE > 1) ? $clog2(NUM_EDGE_PE) : 1;

  // One entry written into the downstream FV FIFO; valid doubles as the write strobe.
  typedef struct packed {
    logic                 valid;
    logic [PE_TAG_W-1:0]  PE_tag;
    logic [FV_ADDR_W-1:0] FV_addr;
  } FV_info2FV_FIFO;

  typedef struct packed {
    logic                 valid;
    logic [FV_ADDR_W-1:0] FV_addr;
  } FV_PE2FV_REQ;

endpackage

// File: rtl/fv_req_arbiter_if.sv
// rtl/fv_req_arbiter_if.sv - per-PE FV fetch request bundle between Edge PEs and the arbiter
interface fv_req_arbiter_if
  import fv_req_arbiter_pkg::*;
#(
  parameter int NUM_PE = NUM_EDGE_PE,
  parameter int ADDR_W = FV_ADDR_W
);

  logic [NUM_PE-1:0]             req_valid;
  logic [NUM_PE-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_PE-1:0]             req_ready;

  modport master (output req_valid, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_addr, output req_ready);

endinterface

// File: rtl/fv_req_arbiter_rr.sv
// rtl/fv_req_arbiter_rr.sv - combinational round-robin pick of one pending PE starting at rr_ptr
module fv_rr_arbiter #(
  parameter int NUM_PE = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_PE-1:0] pend_v,
  input  logic [PTR_W-1:0]  rr_ptr,
  input  logic              enable,
  output logic [NUM_PE-1:0] grant,
  output logic [PTR_W-1:0]  grant_idx
);

  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (enable) begin
      for (int i = 0; i < NUM_PE; i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= NUM_PE) idx = idx - NUM_PE;
        if (!found && pend_v[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = PTR_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/fv_req_arbiter.sv
// rtl/fv_req_arbiter.sv - merges per-PE FV fetch requests into one FV FIFO write stream
module fv_req_arbiter
  import fv_req_arbiter_pkg::*;
#(
  parameter int NUM_PE = NUM_EDGE_PE,
  parameter int ADDR_W = $clog2(MAX_FV_NUM) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  fv_req_arbiter_if.slave       req,
  input  logic [ADDR_W-1:0]     Num_FV,
  input  logic                  wfull,
  output FV_info2FV_FIFO        wdata,
  output logic                  err_oor,
  output logic [7:0]            drop_cnt
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [NUM_PE-1:0]             pend_v;
  logic [NUM_PE-1:0][ADDR_W-1:0] pend_addr;
  logic [PTR_W-1:0]              rr_ptr;
  logic [NUM_PE-1:0]             grant;
  logic [PTR_W-1:0]              grant_idx;
  logic [NUM_PE-1:0]             ready;
  logic [NUM_PE-1:0]             accept;
  logic [NUM_PE-1:0]             store;
  logic [NUM_PE-1:0]             drop;
  logic [8:0]                    drop_sum;

  fv_rr_arbiter #(
    .NUM_PE (NUM_PE),
    .PTR_W  (PTR_W)
  ) u_rr (
    .pend_v    (pend_v),
    .rr_ptr    (rr_ptr),
    .enable    (!wfull),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A granted slot frees up this cycle, so the same PE may refill it immediately.
  assign ready         = ~pend_v | grant;
  assign req.req_ready = ready;
  assign accept        = req.req_valid & ready;

  always_comb begin
    store    = '0;
    drop     = '0;
    drop_sum = {1'b0, drop_cnt};
    for (int k = 0; k < NUM_PE; k++) begin
      store[k] = accept[k] && (req.req_addr[k] < Num_FV);
      drop[k]  = accept[k] && !(req.req_addr[k] < Num_FV);
      drop_sum = drop_sum + 9'(drop[k]);
    end
  end

  always_comb begin
    wdata         = '0;
    wdata.valid   = |grant;
    wdata.PE_tag  = PE_TAG_W'(grant_idx);
    wdata.FV_addr = FV_ADDR_W'(pend_addr[grant_idx]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v    <= '0;
      pend_addr <= '0;
      rr_ptr    <= '0;
      err_oor   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      for (int k = 0; k < NUM_PE; k++) begin
        if (store[k]) begin
          pend_v[k]    <= 1'b1;
          pend_addr[k] <= req.req_addr[k];
        end else if (grant[k]) begin
          pend_v[k]    <= 1'b0;
        end
      end
      if (|grant) rr_ptr <= (grant_idx == PTR_W'(NUM_PE - 1)) ? '0 : grant_idx + 1'b1;
      if (|drop) err_oor <= 1'b1;
      drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_fv_req_arbiter.sv
// tb/tb_fv_req_arbiter.sv - directed scoreboard bench for fv_req_arbiter
module tb_fv_req_arbiter;
  import fv_req_arbiter_pkg::*;

  typedef struct {
    int tag;
    int addr;
  } exp_t;

  logic           clk;
  logic           reset;
  logic [6:0]     Num_FV;
  logic           wfull;
  FV_info2FV_FIFO wdata;
  logic           err_oor;
  logic [7:0]     drop_cnt;

  int   tests_run;
  int   failed;
  exp_t exp_q[$];

  fv_req_arbiter_if #(.NUM_PE(4), .ADDR_W(7)) rif ();

  fv_req_arbiter #(.NUM_PE(4), .ADDR_W(7)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (rif),
    .Num_FV   (Num_FV),
    .wfull    (wfull),
    .wdata    (wdata),
    .err_oor  (err_oor),
    .drop_cnt (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input int tag, input int addr);
    exp_t e;
    e.tag  = tag;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  // Every FIFO write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wdata.valid === 1'b1) begin
      check("write_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_tag", 32'(wdata.PE_tag), e.tag);
        check("sb_addr", 32'(wdata.FV_addr), e.addr);
      end
    end
  end

  initial begin
    int n;
    tests_run         = 0;
    failed            = 0;
    reset             = 1'b1;
    wfull             = 1'b0;
    Num_FV            = 7'd10;
    rif.req_valid     = '0;
    rif.req_addr      = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(rif.req_ready), 32'hF);
    check("rst_valid", 32'(wdata.valid), 0);
    check("rst_err", 32'(err_oor), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    reset = 1'b0;

    // Single request, one-cycle latency, one write.
    rif.req_valid    = 4'b0100;
    rif.req_addr[2]  = 7'd5;
    expect_write(2, 5);
    check("s1_ready", 32'(rif.req_ready[2]), 1);
    tick();
    rif.req_valid = '0;
    @(negedge clk);
    check("s1_valid", 32'(wdata.valid), 1);
    check("s1_tag", 32'(wdata.PE_tag), 2);
    check("s1_addr", 32'(wdata.FV_addr), 5);
    @(negedge clk);
    check("s1_one_cycle", 32'(wdata.valid), 0);
    tick();

    // Reset brings rr_ptr back to 0; all four PEs then drain in order.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rif.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      rif.req_addr[i] = 7'(i + 1);
      expect_write(i, i + 1);
    end
    tick();
    rif.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s2_valid", 32'(wdata.valid), 1);
      check("s2_tag", 32'(wdata.PE_tag), i);
    end
    tick();
    rif.req_valid   = 4'b1001;
    rif.req_addr[0] = 7'd7;
    rif.req_addr[3] = 7'd8;
    expect_write(0, 7);
    expect_write(3, 8);
    tick();
    rif.req_valid = '0;
    @(negedge clk);
    check("s2_rr_first", 32'(wdata.PE_tag), 0);
    @(negedge clk);
    check("s2_rr_second", 32'(wdata.PE_tag), 3);
    @(negedge clk);
    check("s2_rr_idle", 32'(wdata.valid), 0);
    tick();

    // Backpressure: nothing written while wfull, entries kept exactly once.
    wfull           = 1'b1;
    rif.req_valid   = 4'b1010;
    rif.req_addr[1] = 7'd6;
    rif.req_addr[3] = 7'd9;
    expect_write(1, 6);
    expect_write(3, 9);
    tick();
    rif.req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("s3_hold", 32'(wdata.valid), 0);
      check("s3_ready", 32'(rif.req_ready), 32'h5);
    end
    tick();
    wfull = 1'b0;
    @(negedge clk);
    check("s3_first", 32'(wdata.PE_tag), 1);
    @(negedge clk);
    check("s3_second", 32'(wdata.PE_tag), 3);
    @(negedge clk);
    check("s3_idle", 32'(wdata.valid), 0);
    tick();

    // Out-of-range requests are accepted and dropped.
    Num_FV          = 7'd12;
    rif.req_valid   = 4'b0001;
    rif.req_addr[0] = 7'd12;
    check("s4_ready", 32'(rif.req_ready[0]), 1);
    tick();
    rif.req_valid = '0;
    check("s4_err", 32'(err_oor), 1);
    check("s4_drop1", 32'(drop_cnt), 1);
    @(negedge clk);
    check("s4_nowrite", 32'(wdata.valid), 0);
    tick();
    rif.req_valid   = 4'b0111;
    rif.req_addr[0] = 7'd12;
    rif.req_addr[1] = 7'd13;
    rif.req_addr[2] = 7'd127;
    tick();
    rif.req_valid = '0;
    check("s4_drop_multi", 32'(drop_cnt), 4);
    rif.req_valid   = 4'b0001;
    rif.req_addr[0] = 7'd11;
    expect_write(0, 11);
    tick();
    rif.req_valid = '0;
    check("s4_edge_kept", 32'(drop_cnt), 4);
    @(negedge clk);
    check("s4_edge_addr", 32'(wdata.FV_addr), 11);
    tick();

    // A stored entry is not rechecked after Num_FV shrinks.
    wfull           = 1'b1;
    rif.req_valid   = 4'b0100;
    rif.req_addr[2] = 7'd9;
    expect_write(2, 9);
    tick();
    rif.req_valid = '0;
    Num_FV        = 7'd5;
    tick();
    wfull = 1'b0;
    @(negedge clk);
    check("s4_nfv_valid", 32'(wdata.valid), 1);
    check("s4_nfv_addr", 32'(wdata.FV_addr), 9);
    tick();

    // Saturation of the drop counter.
    rif.req_valid   = 4'b0001;
    rif.req_addr[0] = 7'd12;
    repeat (250) tick();
    check("s4_drop_254", 32'(drop_cnt), 254);
    check("s4_sat_ready", 32'(rif.req_ready[0]), 1);
    repeat (50) tick();
    rif.req_valid = '0;
    check("s4_drop_sat", 32'(drop_cnt), 255);
    check("s4_err_sticky", 32'(err_oor), 1);

    // Single PE streaming one write per cycle.
    Num_FV = 7'd40;
    for (int i = 0; i < 8; i++) begin
      rif.req_valid   = 4'b0010;
      rif.req_addr[1] = 7'(20 + i);
      expect_write(1, 20 + i);
      tick();
      @(negedge clk);
      check("s5_valid", 32'(wdata.valid), 1);
      check("s5_tag", 32'(wdata.PE_tag), 1);
      check("s5_addr", 32'(wdata.FV_addr), 20 + i);
    end
    rif.req_valid = '0;
    @(negedge clk);
    check("s5_end", 32'(wdata.valid), 0);
    tick();

    // Asynchronous reset with three entries pending; nothing replays afterwards.
    wfull           = 1'b1;
    rif.req_valid   = 4'b0111;
    rif.req_addr[0] = 7'd1;
    rif.req_addr[1] = 7'd2;
    rif.req_addr[2] = 7'd3;
    tick();
    rif.req_valid = '0;
    @(negedge clk);
    check("s6_blocked", 32'(wdata.valid), 0);
    tick();
    wfull = 1'b0;
    #1;
    check("s6_pre", 32'(wdata.valid), 1);
    reset = 1'b1;
    #1;
    check("s6_async_valid", 32'(wdata.valid), 0);
    check("s6_async_ready", 32'(rif.req_ready), 32'hF);
    tick();
    reset = 1'b0;
    check("s6_err_clr", 32'(err_oor), 0);
    check("s6_drop_clr", 32'(drop_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s6_no_replay", 32'(wdata.valid), 0);
    end
    tick();
    rif.req_valid   = 4'b0010;
    rif.req_addr[1] = 7'd4;
    expect_write(1, 4);
    tick();
    rif.req_valid = '0;
    @(negedge clk);
    check("s6_new_valid", 32'(wdata.valid), 1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
